// File: rtl/iter_alu_if.sv
// Request/response bundle between the ALU controller and the iterative execute unit.
// The controller owns the request side; the execute unit owns busy/done/result/flags.
interface iter_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             overflow;

  modport master (
    output start, ALUControl, a, b,
    input  busy, done, result, zero, neg, carry, overflow
  );

  modport slave (
    input  start, ALUControl, a, b,
    output busy, done, result, zero, neg, carry, overflow
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle execute unit: logic and add/sub finish in one cycle, while shifts
// walk one bit position per cycle through an internal working register.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  iter_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             left_q, left_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum;

  // Single-position shift; right shifts take the fill bit latched at accept time.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic left,
                                              input logic fill);
    if (left) return {v[WIDTH-2:0], 1'b0};
    return {fill, v[WIDTH-1:1]};
  endfunction

  assign is_sub = (bus.ALUControl == 3'b001);
  assign b_sel  = is_sub ? ~bus.b : bus.b;
  assign sum    = {1'b0, bus.a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    left_d   = left_q;
    fill_d   = fill_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          case (bus.ALUControl)
            3'b000, 3'b001: begin
              result_d = sum[WIDTH-1:0];
              carry_d  = sum[WIDTH];
              if (is_sub)
                ovf_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
              else
                ovf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b010: result_d = bus.a & bus.b;
            3'b011: result_d = bus.a | bus.b;
            3'b111: result_d = bus.a ^ bus.b;
            default: begin
              // Zero-length shifts complete immediately with the operand unchanged.
              if (bus.b[SHW-1:0] == '0) begin
                result_d = bus.a;
              end else begin
                done_d  = 1'b0;
                carry_d = carry_q;
                ovf_d   = ovf_q;
                work_d  = bus.a;
                cnt_d   = bus.b[SHW-1:0];
                left_d  = (bus.ALUControl == 3'b110);
                fill_d  = (bus.ALUControl == 3'b100) & bus.a[WIDTH-1];
                state_d = SHIFT;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        work_d = shift1(work_q, left_q, fill_q);
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = work_d;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    zero_d = (result_d == '0);
    neg_d  = result_d[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      fill_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Working register carries no reset: it is always loaded before it is read.
  always_ff @(posedge clk) begin
    work_q <= work_d;
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.neg      = neg_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: hand-computed vectors covering reset, add/sub flags,
// shift latency, busy back-pressure, back-to-back issue and reset mid-shift.
module tb_iter_alu;
  logic clk;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  iter_alu_if #(.WIDTH(32)) bus ();

  iter_alu #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.a          = a;
    bus.b          = b;
  endtask

  // Issue a shift, count cycles to done and busy cycles, then check result.
  task automatic run_shift(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int lat;
    int nbusy;
    issue(op, a, b);
    step();
    bus.start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) nbusy++;
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, nbusy, exp_lat - 1);
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_busy_at_done"}, bus.busy, 1'b0);
    step();
    chk({tag, "_done_single"}, bus.done, 1'b0);
  endtask

  initial begin
    reset          = 1'b0;
    bus.start      = 1'b1;
    bus.ALUControl = 3'b000;
    bus.a          = 32'd1;
    bus.b          = 32'd1;

    // Reset held with start asserted
    step();
    step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_zero", bus.zero, 1'b1);
    chk("rst_neg", bus.neg, 1'b0);
    chk("rst_carry", bus.carry, 1'b0);
    chk("rst_ovf", bus.overflow, 1'b0);
    bus.start = 1'b0;
    reset     = 1'b1;
    step();
    chk("rel_done0", bus.done, 1'b0);
    step();
    chk("rel_done1", bus.done, 1'b0);

    // add overflow
    issue(3'b000, 32'h7FFFFFFF, 32'h1);
    step();
    bus.start = 1'b0;
    chk("add_done", bus.done, 1'b1);
    chk("add_result", bus.result, 32'h80000000);
    chk("add_ovf", bus.overflow, 1'b1);
    chk("add_neg", bus.neg, 1'b1);
    chk("add_carry", bus.carry, 1'b0);
    chk("add_zero", bus.zero, 1'b0);
    step();
    chk("add_done_clear", bus.done, 1'b0);

    // sub equal -> zero, no borrow
    issue(3'b001, 32'd5, 32'd5);
    step();
    bus.start = 1'b0;
    chk("sub55_done", bus.done, 1'b1);
    chk("sub55_result", bus.result, 32'h0);
    chk("sub55_zero", bus.zero, 1'b1);
    chk("sub55_carry", bus.carry, 1'b1);
    chk("sub55_ovf", bus.overflow, 1'b0);
    step();

    // sub with borrow
    issue(3'b001, 32'd3, 32'd5);
    step();
    bus.start = 1'b0;
    chk("sub35_result", bus.result, 32'hFFFFFFFE);
    chk("sub35_carry", bus.carry, 1'b0);
    chk("sub35_neg", bus.neg, 1'b1);
    chk("sub35_ovf", bus.overflow, 1'b0);
    step();

    // sub signed overflow: 0x80000000 - 1
    issue(3'b001, 32'h80000000, 32'h1);
    step();
    bus.start = 1'b0;
    chk("subovf_result", bus.result, 32'h7FFFFFFF);
    chk("subovf_ovf", bus.overflow, 1'b1);
    chk("subovf_carry", bus.carry, 1'b1);
    step();

    // Shifts
    run_shift("sll4", 3'b110, 32'h1, 32'hFFFFFFE4, 5, 32'h10);
    chk("sll4_carry", bus.carry, 1'b0);
    run_shift("sra31", 3'b100, 32'h80000000, 32'd31, 32, 32'hFFFFFFFF);
    chk("sra31_neg", bus.neg, 1'b1);
    run_shift("srl31", 3'b101, 32'h80000000, 32'd31, 32, 32'h1);
    run_shift("sra_pos", 3'b100, 32'h40000000, 32'd2, 3, 32'h10000000);
    run_shift("srl0", 3'b101, 32'h9, 32'h0, 1, 32'h9);

    // Back-pressure: xor issued during busy must be ignored
    issue(3'b101, 32'hF0, 32'd4);
    step();
    chk("bp_busy1", bus.busy, 1'b1);
    issue(3'b111, 32'h1, 32'h1);
    step();
    bus.start = 1'b0;
    chk("bp_busy2", bus.busy, 1'b1);
    chk("bp_done2", bus.done, 1'b0);
    step();
    step();
    chk("bp_busy4", bus.busy, 1'b1);
    step();
    chk("bp_done5", bus.done, 1'b1);
    chk("bp_result", bus.result, 32'h0F);
    step();
    chk("bp_done6", bus.done, 1'b0);
    chk("bp_busy6", bus.busy, 1'b0);
    step();
    chk("bp_done7", bus.done, 1'b0);
    chk("bp_result7", bus.result, 32'h0F);

    // Back-to-back and/or/xor
    issue(3'b010, 32'h0000F0F0, 32'h0000FF00);
    step();
    chk("b2b_and_done", bus.done, 1'b1);
    chk("b2b_and", bus.result, 32'h0000F000);
    issue(3'b011, 32'h0000F0F0, 32'h0000FF00);
    step();
    chk("b2b_or_done", bus.done, 1'b1);
    chk("b2b_or", bus.result, 32'h0000FFF0);
    issue(3'b111, 32'h0000F0F0, 32'h0000FF00);
    step();
    bus.start = 1'b0;
    chk("b2b_xor_done", bus.done, 1'b1);
    chk("b2b_xor", bus.result, 32'h00000FF0);
    chk("b2b_xor_carry", bus.carry, 1'b0);
    step();
    chk("b2b_done_clear", bus.done, 1'b0);

    // Reset mid-shift abandons the operation
    issue(3'b110, 32'h1, 32'd10);
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    step();
    chk("mid_busy", bus.busy, 1'b1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_result", bus.result, 32'h0);
    chk("mid_rst_done", bus.done, 1'b0);
    chk("mid_rst_zero", bus.zero, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mid_no_done", bus.done, 1'b0);
    end
    issue(3'b000, 32'd2, 32'd3);
    step();
    bus.start = 1'b0;
    chk("post_add_done", bus.done, 1'b1);
    chk("post_add_result", bus.result, 32'd5);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Multi-cycle execute unit directly downstream of the ALU decoder. Consumes the decoder's 3-bit ALUControl plus two operands and produces a registered result and flags.
- Logic and add/sub ops complete in one cycle. Shifts run iteratively, one bit position per cycle, to save area.
- Start/done handshake; busy back-pressures the controller while a shift is in flight.

Parameters:
- WIDTH, 32, operand/result width. Must be a power of two, at least 8.
- SHW, $clog2(WIDTH) (localparam), shift-amount width. Taken from b[SHW-1:0].

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on rising edge of clk.
- start  input  1  request; accepted on a rising edge when start=1 and busy=0.
- ALUControl  input  3  op code: 000 add, 001 sub, 010 and, 011 or, 100 sra, 101 srl, 110 sll, 111 xor.
- a  input  WIDTH  operand A (value to shift for shift ops).
- b  input  WIDTH  operand B; shift amount = b[SHW-1:0], upper bits ignored for shifts.
- busy  output  1  high while a shift is iterating.
- done  output  1  one-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  registered result, held until the next accepted start completes.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH-1].
- carry  output  1  add: carry-out. sub: 1 when a >= b unsigned (no borrow). All other ops: 0.
- overflow  output  1  signed overflow for add/sub. All other ops: 0.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; busy=0, done=0, result=0, zero=1, neg=0, carry=0, overflow=0, internal counter=0.
- Reset wins over everything, including mid-shift. An in-flight operation is abandoned with no done pulse.
- States:
  - IDLE (busy=0). SHIFT (busy=1).
  - Start accepted only when busy=0. Start while busy=1 is ignored, with no effect on the operation in flight.
- Non-shift op accepted at edge ending cycle T:
  - result and flags are registered at that edge; done=1 in cycle T+1; state stays IDLE.
  - Latency is 1.
- Shift op accepted at edge ending cycle T with amount n = b[SHW-1:0]:
  - n=0: result=a, done=1 in cycle T+1, state stays IDLE.
  - n>0: latch a into the working register, counter=n, go to SHIFT.
  - Each SHIFT edge shifts the working register one position and decrements the counter:
    - sll: fill 0 from the LSB.
    - srl: fill 0 from the MSB.
    - sra: fill with the original a[WIDTH-1].
  - On the edge where the counter goes 1→0: move to IDLE and set done=1.
  - done=1 in cycle T+1+n; busy=1 in cycles T+1 .. T+n.
  - Total latency is 1+n; maximum is WIDTH.
  - result does not change during SHIFT. The working register is internal, and result is updated only on completion.
- done lasts exactly one cycle. It is low in every other cycle.
- start in the same cycle as done=1 is accepted, since busy=0. Back-to-back ops are therefore possible: one-cycle ops can issue every cycle.
- Flags are computed from the final result and registered together with it, valid in the done cycle.
- Add/sub use WIDTH+1-bit arithmetic. Sub is a + ~b + 1, and carry is that sum's bit WIDTH.
- Overflow rules:
  - add: (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - sub: (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
- Operands and ALUControl are sampled only at the accepting edge. Later changes during SHIFT have no effect.
- No X propagation: all 8 codes are defined.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> busy=0, done=0, result=0, zero=1. Then release, with no done until a new start is accepted.
- Add/sub flags:
  - start add a=32'h7FFFFFFF, b=1 -> next cycle done=1, result=32'h80000000, overflow=1, neg=1, carry=0.
  - start sub a=5, b=5 -> result=0, zero=1, carry=1.
  - start sub a=3, b=5 -> result=32'hFFFFFFFE, carry=0, neg=1.
- Shift latency:
  - sll a=1, b=32'hFFFFFFE4 (n=4) -> busy cycles T+1..T+4, done at T+5, result=16.
  - sra a=32'h80000000, n=31 -> done at T+32, result=32'hFFFFFFFF.
  - srl n=0, a=9 -> done at T+1, result=9.
- Busy back-pressure: start srl a=32'hF0, n=4. Assert start with xor a=1, b=1 during busy -> ignored; single done at T+5 with result=32'h0F; no second done.
- Back-to-back: start and, or, xor on three consecutive cycles, each accepted -> done in three consecutive cycles with correct results each cycle.
- Reset mid-shift: start sll n=10, pull reset=0 at T+5 -> busy=0 and result=0 next cycle; no done pulse. A following add 2+3 gives result=5 at latency 1.
